// File: rtl/fcap_pkg.sv
// Shared definitions for the multi-channel frequency capture front end.
// Optional feature macro: FCAP_TIMEOUT_EN (no-edge timeout results).
package fcap_pkg;

    // Channel FSM encoding
    typedef logic [1:0] fcap_state_t;
    localparam fcap_state_t ST_IDLE = 2'd0;
    localparam fcap_state_t ST_ARM  = 2'd1;
    localparam fcap_state_t ST_MEAS = 2'd2;

    // Bit positions inside res_flags = {timeout, overrun, saturated}
    localparam int unsigned FLAG_SAT = 0;
    localparam int unsigned FLAG_OVR = 1;
    localparam int unsigned FLAG_TMO = 2;
    localparam int unsigned FLAG_W   = 3;

    // Width of a channel index; a single channel still needs one bit
    function automatic int unsigned ch_width(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/fcap_channel.sv
// One capture channel: synchroniser, edge detect, FSM, saturating period and
// high-time counters, window accumulators and the pending result register.
// Optional feature macro: FCAP_TIMEOUT_EN (no-edge timeout results).
module fcap_channel
    import fcap_pkg::*;
#(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 5000000,
    localparam int unsigned SUM_W   = CNT_W + AVG_LOG2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    input  logic              clr,
    output logic              pend,
    output logic              upd,
    output logic [SUM_W-1:0]  pend_period,
    output logic [SUM_W-1:0]  pend_high,
    output logic [FLAG_W-1:0] pend_flags
);

    typedef struct packed {
        logic [SUM_W-1:0]  period_sum;
        logic [SUM_W-1:0]  high_sum;
        logic [FLAG_W-1:0] flags;
    } result_t;

    localparam int unsigned     EDGE_W    = AVG_LOG2 + 1;
    localparam int unsigned     LAST_EDGE = (1 << AVG_LOG2) - 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic              s1, s2, s3;
    logic              rise, fall;
    fcap_state_t       state;
    logic [CNT_W-1:0]  per_cnt, hi_cnt;
    logic              hi_run;
    logic [SUM_W-1:0]  acc_p, acc_h, sum_p, sum_h;
    logic [EDGE_W-1:0] edge_cnt;
    logic              sat_win, sat_now;
    logic              publish, tmo_hit, pub_any;
    result_t           pend_res, pub_res;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s1, s2, s3} <= '0;
        else     {s1, s2, s3} <= {sig_in, s1, s2};
    end

`ifdef FCAP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // No-edge counter: cycles since the last rising edge while measuring
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 tmo_cnt <= '0;
        else if (!en || state != ST_MEAS || rise) tmo_cnt <= TMO_W'(1);
        else                                     tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = en && (state == ST_MEAS) && !rise && (tmo_cnt >= TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Window totals including the period closing on the current edge
    always_comb begin
        sum_p   = acc_p + SUM_W'(per_cnt);
        sum_h   = acc_h + SUM_W'(hi_cnt);
        sat_now = sat_win | (per_cnt == CNT_MAX) | (hi_cnt == CNT_MAX);
        publish = en && (state == ST_MEAS) && rise && (edge_cnt == EDGE_W'(LAST_EDGE));
        pub_any = publish | tmo_hit;
        pub_res = '0;
        if (!tmo_hit) begin
            pub_res.period_sum       = sum_p;
            pub_res.high_sum         = sum_h;
            pub_res.flags[FLAG_SAT]  = sat_now;
        end
        pub_res.flags[FLAG_TMO] = tmo_hit;
        // A result taken on this same edge frees the slot, so no overrun
        pub_res.flags[FLAG_OVR] = pend & ~clr;
    end

    // Measurement FSM with counters and accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            state    <= ST_IDLE;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            hi_run   <= 1'b0;
            acc_p    <= '0;
            acc_h    <= '0;
            edge_cnt <= '0;
            sat_win  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        state   <= ST_MEAS;
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        hi_run  <= 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (tmo_hit) begin
                        state    <= ST_ARM;
                        per_cnt  <= '0;
                        hi_cnt   <= '0;
                        hi_run   <= 1'b0;
                        acc_p    <= '0;
                        acc_h    <= '0;
                        edge_cnt <= '0;
                        sat_win  <= 1'b0;
                    end else if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        hi_run  <= 1'b1;
                        if (publish) begin
                            acc_p    <= '0;
                            acc_h    <= '0;
                            edge_cnt <= '0;
                            sat_win  <= 1'b0;
                        end else begin
                            acc_p    <= sum_p;
                            acc_h    <= sum_h;
                            edge_cnt <= edge_cnt + 1'b1;
                            sat_win  <= sat_now;
                        end
                    end else begin
                        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
                        if (hi_run) begin
                            if (fall)                  hi_run <= 1'b0;
                            else if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pending result register; upd marks a freshly written result for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            upd      <= 1'b0;
            pend_res <= '0;
        end else begin
            upd <= pub_any;
            if (pub_any) begin
                pend     <= 1'b1;
                pend_res <= pub_res;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end

    assign pend_period = pend_res.period_sum;
    assign pend_high   = pend_res.high_sum;
    assign pend_flags  = pend_res.flags;

endmodule

// File: rtl/multi_channel_freq_capture.sv
// Multi-channel capture front end: CH capture channels, a round-robin arbiter
// over pending results and a registered valid/ready result port.
// Optional feature macro: FCAP_TIMEOUT_EN (no-edge timeout results).
module multi_channel_freq_capture
    import fcap_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 5000000,
    localparam int unsigned CHW     = ch_width(CH),
    localparam int unsigned SUM_W   = CNT_W + AVG_LOG2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CH-1:0]     sig_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CHW-1:0]    res_ch,
    output logic [SUM_W-1:0]  res_period_sum,
    output logic [SUM_W-1:0]  res_high_sum,
    output logic [FLAG_W-1:0] res_flags
);

    logic [CH-1:0]     pend, upd, clr, avail;
    logic [SUM_W-1:0]  ch_period [CH];
    logic [SUM_W-1:0]  ch_high   [CH];
    logic [FLAG_W-1:0] ch_flags  [CH];
    logic              fire, gnt_found;
    logic [CHW-1:0]    ptr, gnt_idx, nxt_ptr;
    int unsigned       idx;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        fcap_channel #(
            .CNT_W    (CNT_W),
            .AVG_LOG2 (AVG_LOG2),
            .TIMEOUT  (TIMEOUT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .sig_in      (sig_in[g]),
            .clr         (clr[g]),
            .pend        (pend[g]),
            .upd         (upd[g]),
            .pend_period (ch_period[g]),
            .pend_high   (ch_high[g]),
            .pend_flags  (ch_flags[g])
        );
    end

    assign fire = res_valid & res_ready;

    // Round-robin pick starting at ptr. A transfer whose channel was
    // overwritten in the same cycle delivered stale data, so its pending bit
    // is kept and the newer result is offered again.
    always_comb begin
        clr = '0;
        if (fire && !upd[res_ch]) clr[res_ch] = 1'b1;
        avail     = pend & ~clr;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        nxt_ptr   = ptr;
        for (int unsigned k = 0; k < CH; k++) begin
            idx = (int'(ptr) + k) % CH;
            if (!gnt_found && avail[idx[CHW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[CHW-1:0];
                nxt_ptr   = CHW'((idx + 1) % CH);
            end
        end
    end

    // Output register: load a new grant when empty or draining, otherwise hold;
    // a held result that was overwritten by a newer publish is refreshed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid      <= 1'b0;
            res_ch         <= '0;
            res_period_sum <= '0;
            res_high_sum   <= '0;
            res_flags      <= '0;
            ptr            <= '0;
        end else if (!res_valid || fire) begin
            res_valid <= gnt_found;
            if (gnt_found) begin
                res_ch         <= gnt_idx;
                res_period_sum <= ch_period[gnt_idx];
                res_high_sum   <= ch_high[gnt_idx];
                res_flags      <= ch_flags[gnt_idx];
                ptr            <= nxt_ptr;
            end
        end else if (upd[res_ch]) begin
            res_period_sum <= ch_period[res_ch];
            res_high_sum   <= ch_high[res_ch];
            res_flags      <= ch_flags[res_ch];
        end
    end

endmodule
